// File: rtl/motor_drive_ctrl.sv
// Dual-wheel motor drive controller: filters the 2-bit steering command, sequences
// IDLE/RUN/DEAD with coast time between direction changes, and soft-starts the PWM duties.
module motor_drive_ctrl #(
    parameter int PWM_W         = 10,
    parameter int DUTY_FWD      = 768,
    parameter int DUTY_FAST     = 768,
    parameter int DUTY_SLOW     = 256,
    parameter int RAMP_STEP     = 128,
    parameter int FILTER_CYCLES = 4,
    parameter int DEAD_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_motor,
    output logic [1:0] right_motor,
    output logic       busy
);
    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PWM_W-1:0] CNT_MAX = '1;
    localparam logic [PWM_W-1:0] D_FWD   = PWM_W'(DUTY_FWD);
    localparam logic [PWM_W-1:0] D_FAST  = PWM_W'(DUTY_FAST);
    localparam logic [PWM_W-1:0] D_SLOW  = PWM_W'(DUTY_SLOW);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [PWM_W-1:0] cnt_q;
    logic [1:0]       cmd_q, cmd_d, prev_q;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             new_q, new_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [PWM_W-1:0] lduty_q, lduty_d, rduty_q, rduty_d;
    logic [PWM_W-1:0] ltgt, rtgt;
    logic             lpwm_q, lpwm_d, rpwm_q, rpwm_d;

    // Sum is taken one bit wider so a large step near full scale cannot wrap.
    function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] cur,
                                              input logic [PWM_W-1:0] tgt);
        logic [PWM_W:0] sum;
        sum = {1'b0, cur} + (PWM_W+1)'(RAMP_STEP);
        if (cur >= tgt || sum >= {1'b0, tgt}) ramp = tgt;
        else                                  ramp = sum[PWM_W-1:0];
    endfunction

    always_comb begin
        ltgt = '0;
        rtgt = '0;
        case (cmd_q)
            2'b11: begin ltgt = D_FWD;  rtgt = D_FWD;  end
            2'b01: begin ltgt = D_SLOW; rtgt = D_FAST; end
            2'b10: begin ltgt = D_FAST; rtgt = D_SLOW; end
            default: ;
        endcase
    end

    // Filter counter runs only while the input differs from the accepted command
    // and restarts whenever the input differs from its previous sample.
    always_comb begin
        cmd_d  = cmd_q;
        new_d  = 1'b0;
        fcnt_d = '0;
        if (state != cmd_q) begin
            fcnt_d = (state == prev_q) ? fcnt_q + FW'(1) : '0;
            if (fcnt_d == FW'(FILTER_CYCLES - 1)) begin
                cmd_d  = state;
                new_d  = 1'b1;
                fcnt_d = '0;
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        dcnt_d  = '0;
        lduty_d = lduty_q;
        rduty_d = rduty_q;
        case (fsm_q)
            IDLE: begin
                lduty_d = '0;
                rduty_d = '0;
                if (new_q && cmd_q != 2'b00) fsm_d = RUN;
            end
            RUN: begin
                if (new_q) begin
                    lduty_d = '0;
                    rduty_d = '0;
                    fsm_d   = (cmd_q == 2'b00) ? IDLE : DEAD;
                end else if (cnt_q == CNT_MAX) begin
                    lduty_d = ramp(lduty_q, ltgt);
                    rduty_d = ramp(rduty_q, rtgt);
                end
            end
            DEAD: begin
                lduty_d = '0;
                rduty_d = '0;
                if (new_q) begin
                    if (cmd_q == 2'b00) fsm_d = IDLE;
                end else if (dcnt_q == DW'(DEAD_CYCLES - 1)) begin
                    fsm_d = RUN;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase
        // Leaving RUN silences the outputs on the same edge.
        lpwm_d = (fsm_d == RUN) && (cnt_q < lduty_q);
        rpwm_d = (fsm_d == RUN) && (cnt_q < rduty_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= 2'b00;
            prev_q  <= 2'b00;
            fcnt_q  <= '0;
            new_q   <= 1'b0;
            dcnt_q  <= '0;
            lduty_q <= '0;
            rduty_q <= '0;
            lpwm_q  <= 1'b0;
            rpwm_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_q + PWM_W'(1);
            cmd_q   <= cmd_d;
            prev_q  <= state;
            fcnt_q  <= fcnt_d;
            new_q   <= new_d;
            dcnt_q  <= dcnt_d;
            lduty_q <= lduty_d;
            rduty_q <= rduty_d;
            lpwm_q  <= lpwm_d;
            rpwm_q  <= rpwm_d;
        end
    end

    assign left_pwm    = lpwm_q;
    assign right_pwm   = rpwm_q;
    assign left_motor  = (fsm_q == IDLE) ? 2'b00 : 2'b10;
    assign right_motor = (fsm_q == IDLE) ? 2'b00 : 2'b10;
    assign busy        = (fsm_q == DEAD) ||
                         ((fsm_q == RUN) && (lduty_q != ltgt || rduty_q != rtgt));
endmodule
